// File: rtl/wb_queue_pkg.sv
// Shared CPU definitions: register file geometry and the write-back entry
// format that execution units hand to the write-back queue.
package wb_queue_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-first search of the valid queue entries for one read select;
// falls back to the raw register file data when nothing matches.
module wb_fwd_match #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = wb_queue_pkg::DATA_W,
    parameter int ADDR_W = wb_queue_pkg::ADDR_W
) (
    input  logic [$clog2(DEPTH)-1:0] headPtr,
    input  logic [$clog2(DEPTH):0]   validCount,
    input  logic [ADDR_W-1:0]        destArr [DEPTH],
    input  logic [DATA_W-1:0]        dataArr [DEPTH],
    input  logic [ADDR_W-1:0]        sel,
    input  logic [DATA_W-1:0]        rfData,
    output logic [DATA_W-1:0]        fwdData
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  hit;
    logic [DATA_W-1:0] ageData [DEPTH];

    // Slot gi holds the gi-th oldest entry, so the highest hit is the youngest.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PTR_W-1:0] idx;
            assign idx         = headPtr + PTR_W'(gi);
            assign hit[gi]     = (CNT_W'(gi) < validCount) && (destArr[idx] == sel);
            assign ageData[gi] = dataArr[idx];
        end
    endgenerate

    always_comb begin
        fwdData = rfData;
        for (int k = 0; k < DEPTH; k++) begin
            if (hit[k]) fwdData = ageData[k];
        end
    end

endmodule

// File: rtl/wb_queue.sv
// In-order write-back queue feeding the register file write port, with
// forwarding of pending writes onto both read ports.
module wb_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = wb_queue_pkg::DATA_W,
    parameter int ADDR_W = wb_queue_pkg::ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wbValid,
    output logic                     wbReady,
    input  logic [ADDR_W-1:0]        wbDest,
    input  logic [DATA_W-1:0]        wbData,
    input  logic                     portBusy,
    output logic                     regWrite,
    output logic [ADDR_W-1:0]        rd,
    output logic [DATA_W-1:0]        writeData,
    input  logic [ADDR_W-1:0]        rs,
    input  logic [ADDR_W-1:0]        rt,
    input  logic [DATA_W-1:0]        rfR0,
    input  logic [DATA_W-1:0]        rfR1,
    output logic [DATA_W-1:0]        outR0,
    output logic [DATA_W-1:0]        outR1,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] destMem [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];

    logic [PTR_W-1:0] headReg, headNext;
    logic [PTR_W-1:0] tailReg, tailNext;
    logic [CNT_W-1:0] countReg, countNext;
    logic             enq;
    logic             deq;

    assign empty     = (countReg == '0);
    assign full      = (countReg == CNT_W'(DEPTH));
    assign wbReady   = !full;
    assign count     = countReg;
    assign regWrite  = !empty && !portBusy && !reset;
    assign rd        = destMem[headReg];
    assign writeData = dataMem[headReg];
    assign enq       = wbValid && wbReady && !reset;
    assign deq       = regWrite;

    // DEPTH is a power of two, so pointers wrap by plain truncation.
    always_comb begin
        headNext  = headReg;
        tailNext  = tailReg;
        countNext = countReg;
        if (enq) tailNext = tailReg + PTR_W'(1);
        if (deq) headNext = headReg + PTR_W'(1);
        case ({enq, deq})
            2'b10:   countNext = countReg + CNT_W'(1);
            2'b01:   countNext = countReg - CNT_W'(1);
            default: countNext = countReg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            headReg  <= '0;
            tailReg  <= '0;
            countReg <= '0;
        end else begin
            headReg  <= headNext;
            tailReg  <= tailNext;
            countReg <= countNext;
        end
    end

    // Entry storage needs no reset: occupancy alone decides validity.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (enq && (tailReg == PTR_W'(gi))) begin
                    destMem[gi] <= wbDest;
                    dataMem[gi] <= wbData;
                end
            end
        end
    endgenerate

    wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) uFwd0 (
        .headPtr    (headReg),
        .validCount (countReg),
        .destArr    (destMem),
        .dataArr    (dataMem),
        .sel        (rs),
        .rfData     (rfR0),
        .fwdData    (outR0)
    );

    wb_fwd_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) uFwd1 (
        .headPtr    (headReg),
        .validCount (countReg),
        .destArr    (destMem),
        .dataArr    (dataMem),
        .sel        (rt),
        .rfData     (rfR1),
        .fwdData    (outR1)
    );

endmodule
